// File: rtl/svc_rv_dmem_resp_if.sv
// Data-memory bus between the svc_rv core (master) and a memory responder (slave).
// Read data and stall travel back to the core; everything else is core-driven.
interface svc_rv_dmem_resp_if;
  logic        dmem_ren;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_stall;

  modport master (
    output dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_stall
  );

  modport slave (
    input  dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_stall
  );
endinterface

// File: rtl/svc_rv_dmem_resp.sv
// Word-organised data RAM for the svc_rv dmem port with byte-strobed writes,
// registered reads and bounded read-miss stalls from a direct-mapped tag tracker.
module svc_rv_dmem_resp #(
  parameter int DMEM_AW     = 10,
  parameter int STALL_EN    = 1,
  parameter int MISS_CYCLES = 2,
  parameter int LINES       = 4,
  parameter int LINE_BYTES  = 16
) (
  input  logic               clock,
  input  logic               reset,
  svc_rv_dmem_resp_if.slave  dmem,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
);

  localparam int OB    = $clog2(LINE_BYTES);
  localparam int IB    = $clog2(LINES);
  localparam int TL    = OB + IB;
  localparam int TW    = DMEM_AW + 2 - TL;
  localparam int DEPTH = 1 << DMEM_AW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  logic [31:0]             mem_array [DEPTH];
  logic [31:0]             ram_q_reg;
  logic [31:0]             hold_reg;
  logic                    fresh_reg;
  logic [0:0]              state_reg;
  logic [3:0]              cnt_reg;
  logic [31:0]             hits_reg;
  logic [31:0]             misses_reg;
  logic [LINES-1:0]        valid_reg;
  logic [LINES-1:0][TW-1:0] tag_reg;
  logic [IB-1:0]           miss_line_reg;
  logic [TW-1:0]           miss_tag_reg;

  logic [DMEM_AW-1:0]      rword;
  logic [DMEM_AW-1:0]      wword;
  logic [IB-1:0]           rline;
  logic [TW-1:0]           rtag;
  logic                    idle;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    rd_hit;
  logic [LINES-1:0]        line_hit;
  logic [31:0]             rdata_c;
  logic                    unused_addr_bits;

  assign rword = dmem.dmem_raddr[DMEM_AW+1:2];
  assign wword = dmem.dmem_waddr[DMEM_AW+1:2];
  assign rline = dmem.dmem_raddr[TL-1:OB];
  assign rtag  = dmem.dmem_raddr[DMEM_AW+1:TL];

  // Byte-offset and wrap-around address bits carry no meaning here.
  assign unused_addr_bits = ^{dmem.dmem_raddr[31:DMEM_AW+2], dmem.dmem_raddr[1:0],
                              dmem.dmem_waddr[31:DMEM_AW+2], dmem.dmem_waddr[1:0]};

  assign idle   = (state_reg == ST_IDLE);
  assign rd_acc = idle && dmem.dmem_ren && !reset;
  assign wr_acc = idle && dmem.dmem_we  && !reset;

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      assign line_hit[gi] = valid_reg[gi] && (tag_reg[gi] == rtag) && (rline == IB'(gi));
    end
  endgenerate

  assign rd_hit = (STALL_EN == 0) || (|line_hit);

  // Read-first RAM: a same-cycle write to the read word lands after the capture.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem.dmem_wstrb[b]) begin
          mem_array[wword][8*b +: 8] <= dmem.dmem_wdata[8*b +: 8];
        end
      end
    end
    if (rd_acc) begin
      ram_q_reg <= mem_array[rword];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      valid_reg     <= '0;
      fresh_reg     <= 1'b0;
      hold_reg      <= 32'd0;
      hits_reg      <= 32'd0;
      misses_reg    <= 32'd0;
      miss_line_reg <= '0;
      miss_tag_reg  <= '0;
    end else begin
      if (rd_acc) begin
        if (rd_hit) begin
          hits_reg  <= hits_reg + 32'd1;
          fresh_reg <= 1'b1;
        end else begin
          // Freeze the currently visible data; the new word waits in ram_q_reg.
          misses_reg    <= misses_reg + 32'd1;
          state_reg     <= ST_MISS;
          cnt_reg       <= 4'(MISS_CYCLES);
          miss_line_reg <= rline;
          miss_tag_reg  <= rtag;
          hold_reg      <= rdata_c;
          fresh_reg     <= 1'b0;
        end
      end
      if (state_reg == ST_MISS) begin
        cnt_reg <= cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_reg                <= ST_IDLE;
          valid_reg[miss_line_reg] <= 1'b1;
          tag_reg[miss_line_reg]   <= miss_tag_reg;
          fresh_reg                <= 1'b1;
        end
      end
    end
  end

  assign rdata_c         = fresh_reg ? ram_q_reg : hold_reg;
  assign dmem.dmem_rdata = rdata_c;
  assign dmem.dmem_stall = (state_reg == ST_MISS);
  assign stat_hits       = hits_reg;
  assign stat_misses     = misses_reg;

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Randomised bench for svc_rv_dmem_resp against a transaction-level memory/tracker model.
module tb_svc_rv_dmem_resp;
  localparam int MC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  always #5 clock = ~clock;

  svc_rv_dmem_resp_if dmem_bus ();

  svc_rv_dmem_resp #(
    .DMEM_AW(10), .STALL_EN(1), .MISS_CYCLES(MC), .LINES(4), .LINE_BYTES(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dmem        (dmem_bus),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  // Reference model: plain word array, line table and counters.
  logic [31:0] m_mem [1024];
  bit          m_valid [4];
  int unsigned m_tag [4];
  int unsigned m_hits;
  int unsigned m_misses;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % 1024;
  endfunction
  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 16) % 4;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] a);
    return (a >> 6) % 64;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned w;
    w = word_of(a);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
    end
    m_hits   = 0;
    m_misses = 0;
    m_rdata  = 32'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_stall"},  {31'd0, dmem_bus.dmem_stall}, 32'd0);
    check_val({tag, "_rdata"},  dmem_bus.dmem_rdata, 32'd0);
    check_val({tag, "_hits"},   stat_hits, 32'd0);
    check_val({tag, "_misses"}, stat_misses, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dmem_bus.dmem_ren = 1'b0;
    dmem_bus.dmem_we  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check_reset_state("rst");
    $display("reset");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_bus.dmem_we    = 1'b1;
    dmem_bus.dmem_waddr = a;
    dmem_bus.dmem_wdata = d;
    dmem_bus.dmem_wstrb = s;
    @(posedge clock);
    @(negedge clock);
    dmem_bus.dmem_we = 1'b0;
    model_write(a, d, s);
    check_val("wr_stall", {31'd0, dmem_bus.dmem_stall}, 32'd0);
    $display("wr addr=%h data=%h strb=%b", a, d, s);
  endtask

  // Read, optionally with a write accepted in the same cycle.
  task automatic do_access(input logic [31:0] a, input bit rw, input logic [31:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws);
    bit          hit;
    logic [31:0] exp_data;
    int          n;
    hit      = m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
    exp_data = m_mem[word_of(a)];
    dmem_bus.dmem_ren   = 1'b1;
    dmem_bus.dmem_raddr = a;
    if (rw) begin
      dmem_bus.dmem_we    = 1'b1;
      dmem_bus.dmem_waddr = wa;
      dmem_bus.dmem_wdata = wd;
      dmem_bus.dmem_wstrb = ws;
    end
    @(posedge clock);
    @(negedge clock);
    dmem_bus.dmem_ren = 1'b0;
    dmem_bus.dmem_we  = 1'b0;
    if (rw) model_write(wa, wd, ws);
    n = 0;
    if (dmem_bus.dmem_stall === 1'b1) check_val("rdata_hold", dmem_bus.dmem_rdata, m_rdata);
    while (dmem_bus.dmem_stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    check_val("stall_len", n, hit ? 0 : MC);
    check_val("rdata", dmem_bus.dmem_rdata, exp_data);
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      m_valid[line_of(a)] = 1;
      m_tag[line_of(a)]   = tag_of(a);
    end
    m_rdata = exp_data;
    check_val("hits", stat_hits, m_hits);
    check_val("misses", stat_misses, m_misses);
    $display("rd addr=%h data=%h hit=%0d stall=%0d rw=%0d", a, dmem_bus.dmem_rdata, hit, n, rw);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wa;
    int          op;

    dmem_bus.dmem_ren   = 1'b0;
    dmem_bus.dmem_raddr = 32'd0;
    dmem_bus.dmem_we    = 1'b0;
    dmem_bus.dmem_waddr = 32'd0;
    dmem_bus.dmem_wdata = 32'd0;
    dmem_bus.dmem_wstrb = 4'd0;
    reset = 1'b1;
    @(negedge clock);
    do_reset();

    for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom(), 4'hF);

    // Miss then same-line hit.
    do_write(32'h14, 32'hDEADBEEF, 4'hF);
    do_access(32'h14, 0, 32'd0, 32'd0, 4'd0);
    check_val("t1_data", dmem_bus.dmem_rdata, 32'hDEADBEEF);
    check_val("t1_misses", stat_misses, 32'd1);
    do_access(32'h18, 0, 32'd0, 32'd0, 4'd0);
    check_val("t2_hits", stat_hits, 32'd1);

    // Strobed merge.
    do_write(32'h20, 32'hFFFFFFFF, 4'hF);
    do_write(32'h20, 32'h11223344, 4'b0101);
    do_access(32'h20, 0, 32'd0, 32'd0, 4'd0);
    check_val("t3_merge", dmem_bus.dmem_rdata, 32'hFF22FF44);

    // Same-cycle read and write return the old word.
    do_write(32'h30, 32'h0000000A, 4'hF);
    do_access(32'h30, 1, 32'h30, 32'h0000000B, 4'hF);
    check_val("t4_old", dmem_bus.dmem_rdata, 32'h0000000A);
    do_access(32'h30, 0, 32'd0, 32'd0, 4'd0);
    check_val("t4_new", dmem_bus.dmem_rdata, 32'h0000000B);

    // Conflicting tags on one index thrash the entry.
    for (int k = 0; k < 6; k++) do_access((k % 2 == 1) ? 32'h40 : 32'h00, 0, 32'd0, 32'd0, 4'd0);
    check_val("t5_misses", stat_misses, 32'd9);

    // Reset during the first miss cycle.
    dmem_bus.dmem_ren   = 1'b1;
    dmem_bus.dmem_raddr = 32'hC0;
    @(posedge clock);
    @(negedge clock);
    dmem_bus.dmem_ren = 1'b0;
    check_val("mm_stall_pre", {31'd0, dmem_bus.dmem_stall}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check_reset_state("mm");
    $display("reset mid-miss");
    do_access(32'hC0, 0, 32'd0, 32'd0, 4'd0);
    check_val("mm_remiss", stat_misses, 32'd1);

    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      wa = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      if (op == 0) do_write(wa, $urandom(), 4'($urandom_range(0, 15)));
      else if (op == 1) do_access(a, 0, 32'd0, 32'd0, 4'd0);
      else do_access(a, 1, wa, $urandom(), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
